// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum stage is selected with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int unsigned DEPTH_DEFAULT  = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHK   = 3'd4,
`endif
    ST_FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// Collects little-endian bytes into a 32-bit word; last_c marks that the
// next accepted byte completes the word (word_c then holds the full word).
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word_c,
  output logic              last_c
);

  logic [BYTE_IDX_W-1:0]    cnt;
  logic [WORD_W-BYTE_W-1:0] low;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      low <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (accept) begin
      for (int i = 0; i < int'(BYTES_PER_WORD) - 1; i++) begin
        if (cnt == BYTE_IDX_W'(i)) low[i*BYTE_W +: BYTE_W] <= data;
      end
      cnt <= cnt + BYTE_IDX_W'(1);
    end
  end

  // The top byte is never stored: the word is written the cycle it arrives.
  assign word_c = {data, low};
  assign last_c = (cnt == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to append and verify an XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  len, len_nxt;
  logic [CNT_W-1:0]  idx, idx_nxt, idx_inc;
  logic [WORD_W-1:0] addr_nxt, data_nxt, pk_word_c;
  logic              done_nxt, err_nxt, ready_nxt, hold_nxt, wr_en_nxt;
  logic              pk_clear, pk_accept, pk_last_c;
  logic              xfer, len_bad;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum, csum_nxt;
`endif

  assign xfer    = byte_valid & byte_ready;
  assign idx_inc = idx + CNT_W'(1);
  assign len_bad = (byte_data == 8'd0) || (32'(byte_data) > DEPTH);

  byte_packer u_packer (
    .clk    (clk),
    .reset  (reset),
    .clear  (pk_clear),
    .accept (pk_accept),
    .data   (byte_data),
    .word_c (pk_word_c),
    .last_c (pk_last_c)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      len        <= '0;
      idx        <= '0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_nxt;
      len        <= len_nxt;
      idx        <= idx_nxt;
      byte_ready <= ready_nxt;
      wr_en      <= wr_en_nxt;
      wr_addr    <= addr_nxt;
      wr_data    <= data_nxt;
      cpu_hold   <= hold_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= csum_nxt;
`endif
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    idx_nxt   = idx;
    addr_nxt  = wr_addr;
    data_nxt  = wr_data;
    done_nxt  = done;
    err_nxt   = err;
    pk_clear  = 1'b0;
    pk_accept = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_nxt  = csum;
`endif

    case (state)
      ST_IDLE, ST_FIN: begin
        if (start) begin
          done_nxt  = 1'b0;
          err_nxt   = 1'b0;
          pk_clear  = 1'b1;
          state_nxt = ST_LEN;
        end
      end
      ST_LEN: begin
        if (xfer) begin
          if (len_bad) begin
            err_nxt   = 1'b1;
            state_nxt = ST_FIN;
          end else begin
            len_nxt   = CNT_W'(byte_data);
            idx_nxt   = '0;
            pk_clear  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_nxt  = '0;
`endif
            state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          pk_accept = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_nxt  = csum ^ byte_data;
`endif
          if (pk_last_c) begin
            addr_nxt  = 32'({idx, {BYTE_IDX_W{1'b0}}});
            data_nxt  = pk_word_c;
            state_nxt = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        idx_nxt = idx_inc;
        if (idx_inc < len) begin
          state_nxt = ST_DATA;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = ST_CHK;
`else
          state_nxt = ST_FIN;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (xfer) begin
          err_nxt   = (byte_data != csum);
          state_nxt = ST_FIN;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase

    // done rises on entry to FIN only, so a start in FIN can clear it
    if ((state_nxt == ST_FIN) && (state != ST_FIN)) done_nxt = 1'b1;

    wr_en_nxt = (state_nxt == ST_WRITE);
    hold_nxt  = (state_nxt != ST_IDLE) && (state_nxt != ST_FIN);
`ifdef IMEM_LOADER_CHECKSUM_EN
    ready_nxt = (state_nxt == ST_LEN) || (state_nxt == ST_DATA) || (state_nxt == ST_CHK);
`else
    ready_nxt = (state_nxt == ST_LEN) || (state_nxt == ST_DATA);
`endif
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the driver
// and popped by an independent write monitor.
module tb_imem_loader;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  tests = 0;
  int  fails = 0;

  // Write monitor
  always @(negedge clk) begin
    if (reset && wr_en) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write addr=%h data=%h", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
          fails++;
          $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                   wr_addr, wr_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic bit pick_gap(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'($urandom % 2);
    return 1'b0;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    bit rdy;
    ok = 1'b0;
    if (gap) begin
      byte_valid = 1'b0;
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rdy = byte_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL byte_timeout byte=%h", b);
    end
  endtask

  task automatic wait_done(input logic exp_err);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done", 32'(done), 32'd1);
    check("err", 32'(err), 32'(exp_err));
    check("cpu_hold_fin", 32'(cpu_hold), 32'd0);
    check("byte_ready_fin", 32'(byte_ready), 32'd0);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  // Full load; csum_ovr < 0 sends the correct checksum (checksum build only)
  task automatic load(input int n, input logic [7:0] b[$], input int gap_mode,
                      input bit mid_start, input int csum_ovr);
    logic        exp_err;
    logic [7:0]  x;
    logic [31:0] last_a, last_d;
    wr_t         e;
    exp_err = (n == 0) || (n > DEPTH);
    x = 8'd0;
    last_a = 32'd0;
    last_d = 32'd0;
    pulse_start();
    send_byte(8'(n), pick_gap(gap_mode));
    if (!exp_err) begin
      for (int w = 0; w < n; w++) begin
        for (int k = 0; k < 4; k++) begin
          if (k == 3) begin
            e.addr = 32'(w) * 32'd4;
            e.data = 32'(b[4*w]) + 32'(b[4*w+1]) * 32'd256 +
                     32'(b[4*w+2]) * 32'd65536 + 32'(b[4*w+3]) * 32'd16777216;
            exp_q.push_back(e);
            last_a = e.addr;
            last_d = e.data;
          end
          x = x ^ b[4*w+k];
          send_byte(b[4*w+k], pick_gap(gap_mode));
          if (mid_start && w == 0 && k == 1) pulse_start();
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (csum_ovr >= 0) begin
        exp_err = (8'(csum_ovr) != x);
        send_byte(8'(csum_ovr), pick_gap(gap_mode));
      end else begin
        send_byte(x, pick_gap(gap_mode));
      end
`endif
    end
    wait_done(exp_err);
    if (!exp_err || (csum_ovr >= 0)) begin
      check("wr_addr_hold", wr_addr, last_a);
      check("wr_data_hold", wr_data, last_d);
    end
  endtask

  task automatic rand_bytes(input int n, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_wr_addr"}, wr_addr, 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] empty_q[$];
    int n;

    empty_q = {};
    reset = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'd0;
    #12;
    check_all_zero("reset");
    tick();
    reset = 1'b1;
    tick();

    // Single known word
    q = {8'h93, 8'h00, 8'h30, 8'h00};
    load(1, q, 0, 1'b0, -1);

    // Three words, byte_valid toggling
    rand_bytes(3, q);
    load(3, q, 1, 1'b0, -1);

    // Bad lengths
    load(0, empty_q, 0, 1'b0, -1);
    load(DEPTH + 1, empty_q, 1, 1'b0, -1);
    load(200, empty_q, 0, 1'b0, -1);

    // Reset after 6 of 8 data bytes
    rand_bytes(2, q);
    pulse_start();
    send_byte(8'd2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        mon_e.addr = 32'd0;
        mon_e.data = {q[3], q[2], q[1], q[0]};
        exp_q.push_back(mon_e);
      end
      send_byte(q[i], 1'b0);
    end
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    check("midreset_pending", 32'(exp_q.size()), 32'd0);
    tick();
    reset = 1'b1;
    rand_bytes(1, q);
    load(1, q, 0, 1'b0, -1);

    // Start during DATA is ignored
    rand_bytes(2, q);
    load(2, q, 2, 1'b1, -1);

    // Start in FIN clears done and begins a new load
    pulse_start();
    check("fin_start_done", 32'(done), 32'd0);
    check("fin_start_err", 32'(err), 32'd0);
    check("fin_start_hold", 32'(cpu_hold), 32'd1);
    check("fin_start_ready", 32'(byte_ready), 32'd1);
    rand_bytes(1, q);
    load(1, q, 0, 1'b0, -1);

    // Randomized loads
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 8);
      rand_bytes(n, q);
      load(n, q, 2, 1'b0, -1);
    end

    // Full-depth boundary: last write at (DEPTH-1)*4
    rand_bytes(DEPTH, q);
    load(DEPTH, q, 0, 1'b0, -1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    q = {8'h13, 8'h01, 8'h00, 8'h00};
    load(1, q, 0, 1'b0, 32'h12);
    load(1, q, 0, 1'b0, 32'h00);
    rand_bytes(3, q);
    load(3, q, 2, 1'b0, int'($urandom_range(0, 255)));
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 32, SHALL give the instruction-memory capacity in 32-bit words.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse that begins a program load.
REQ-005 byte_valid  input  1  source presents a byte on byte_data.
REQ-006 byte_data  input  8  program stream byte.
REQ-007 byte_ready  output  1  loader accepts a byte this cycle.
REQ-008 wr_en  output  1  instruction-memory write strobe.
REQ-009 wr_addr  output  32  byte address of the written word, always word-aligned.
REQ-010 wr_data  output  32  assembled instruction word.
REQ-011 cpu_hold  output  1  stalls PC update while a load is in progress.
REQ-012 done  output  1  load finished; sticky until the next accepted start.
REQ-013 err  output  1  load aborted; sticky until the next accepted start.

Function
REQ-014 The stream format SHALL be one length byte N followed by 4*N data bytes, each word little-endian (first byte goes to bits 7:0).
REQ-015 The FSM SHALL have states IDLE, LEN, DATA, WRITE, CHK and FIN.
REQ-016 A byte SHALL transfer only in a cycle where byte_valid and byte_ready are both 1.
REQ-017 byte_ready SHALL be 1 only in LEN, DATA and CHK.
REQ-018 In IDLE or FIN, start SHALL clear done and err and move to LEN on the next edge; start in any other state SHALL be ignored.
REQ-019 In LEN, a transferred N with 1<=N<=DEPTH SHALL latch N, clear the word index and the byte counter, and move to DATA.
REQ-020 In LEN, a transferred N equal to 0 or greater than DEPTH SHALL set err and move to FIN, and SHALL produce no write.
REQ-021 In DATA, the fourth transferred byte of a word SHALL move the FSM to WRITE.
REQ-022 WRITE SHALL last exactly one cycle, with wr_en=1, wr_addr=index*4 and wr_data equal to the assembled word.
REQ-023 After WRITE, the word index SHALL increment; the FSM SHALL return to DATA if index<N, otherwise go to CHK (if enabled) or FIN.
REQ-024 The word index SHALL never exceed N-1 at a write, and wr_addr SHALL never reach DEPTH*4.
REQ-025 cpu_hold SHALL be 1 in LEN, DATA, WRITE and CHK, and 0 in IDLE and FIN.
REQ-026 On entry to FIN, done SHALL be set to 1.
REQ-027 wr_addr and wr_data SHALL hold their last values whenever wr_en=0.

Reset
REQ-028 Asserting reset (low) SHALL immediately force state IDLE and set byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err and all counters to 0.
REQ-029 Reset mid-load SHALL discard any partial word and SHALL produce no further write.

Configuration
REQ-030 With IMEM_LOADER_CHECKSUM_EN defined, the loader SHALL keep a running XOR of all data bytes and, after the last word, accept one checksum byte in CHK.
REQ-031 With IMEM_LOADER_CHECKSUM_EN defined, a checksum mismatch SHALL set err and a match SHALL leave err at 0; in both cases the FSM SHALL then go to FIN with done=1.
REQ-032 Without IMEM_LOADER_CHECKSUM_EN, the CHK state and the XOR register SHALL NOT exist, and the FSM SHALL go from the last WRITE directly to FIN.

Structure
REQ-033 Package imem_loader_pkg SHALL hold the state enum typedef, the DEPTH default and the byte-per-word constant (4).
REQ-034 Sub-module byte_packer SHALL assemble four little-endian bytes into a 32-bit word and flag the fourth byte.

Verification
REQ-035 Single word: start, N=1, bytes 93 00 30 00 -> one wr_en pulse with wr_addr=0x0, wr_data=0x00300093; then done=1, cpu_hold=0.
REQ-036 Three words with byte_valid toggling every other cycle -> writes at 0x0, 0x4 and 0x8 with correct data, and no byte lost or duplicated.
REQ-037 Bad length: N=0 and, separately, N=33 with DEPTH=32 -> err=1, done=1, no wr_en.
REQ-038 Reset after 6 of 8 data bytes (N=2) -> all outputs 0 immediately; the following clean load with N=1 writes only address 0x0.
REQ-039 Checksum enabled: N=1 with bytes 13 01 00 00 and checksum 12 -> err=0; the same stream with checksum 00 -> err=1, done=1.
REQ-040 start pulsed during DATA -> ignored; the load completes normally, and start in FIN clears done and restarts.
